mem_arbiter: RTL and testbench

Two-master memory arbiter downstream of the test CPU's bus port. It serialises CPU reads and writes and video/DMA reads onto one synchronous single-port RAM with a configurable number of wait states. It returns each access with a one-cycle `ack` pulse. It is the req/ack responder the CPU's fetch and data engines wait on, including back-to-back word reads where `req` stays high and the address changes right after `ack`.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RELEASE} arb_state_t;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_VID = 1'b1;

  localparam int ACK_LATENCY_BASE = 3;

  // Round-robin pick: on a tie the master that did not finish last wins.
  function automatic logic rr_pick(input logic m0_pend, input logic m1_pend,
                                   input logic last_grant);
    if (m0_pend && m1_pend) return ~last_grant;
    else if (m0_pend)       return MASTER_CPU;
    else                    return MASTER_VID;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Serialises CPU read/write and video/DMA read requests onto one synchronous
// single-port RAM, answering each access with a one-cycle ack pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_rd_req,
  input  logic              m0_wr_en,
  input  logic [7:0]        m0_wr_data,
  output logic [7:0]        m0_rd_data,
  output logic              m0_ack,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_rd_req,
  output logic [7:0]        m1_rd_data,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wr_data,
  input  logic [7:0]        ram_rd_data
);

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("mem_arbiter: WAIT_STATES must be in 0..15");
    end
  endgenerate

  localparam logic [3:0] WCNT_LOAD = 4'(WAIT_STATES);

  arb_state_t state;
  logic       cur;
  logic       last_grant;
  logic       is_write;
  logic [3:0] wcnt;

  logic m0_pend;
  logic m1_pend;
  logic grant;

  assign m0_pend = m0_rd_req | m0_wr_en;
  assign m1_pend = m1_rd_req;
  assign grant   = rr_pick(m0_pend, m1_pend, last_grant);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur         <= MASTER_CPU;
      last_grant  <= MASTER_VID;
      is_write    <= 1'b0;
      wcnt        <= 4'd0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wr_data <= 8'd0;
      m0_rd_data  <= 8'd0;
      m1_rd_data  <= 8'd0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_pend || m1_pend) begin
            cur   <= grant;
            wcnt  <= WCNT_LOAD;
            state <= ACCESS;
            if (grant == MASTER_CPU) begin
              // A write wins over a simultaneous read request.
              ram_addr    <= m0_addr;
              is_write    <= m0_wr_en;
              ram_we      <= m0_wr_en;
              ram_wr_data <= m0_wr_data;
            end else begin
              ram_addr <= m1_addr;
              is_write <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
          else              state <= CAPTURE;
        end
        CAPTURE: begin
          if (!is_write) begin
            if (cur == MASTER_CPU) m0_rd_data <= ram_rd_data;
            else                   m1_rd_data <= ram_rd_data;
          end
          if (cur == MASTER_CPU) m0_ack <= 1'b1;
          else                   m1_ack <= 1'b1;
          last_grant <= cur;
          state      <= RELEASE;
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a zero-wait instance and a three-wait
// instance share stimulus, each with its own RAM model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [15:0] m0_addr, m1_addr;
  logic        m0_rd_req, m0_wr_en, m1_rd_req;
  logic [7:0]  m0_wr_data;

  logic [7:0]  m0_rd_data_w0, m1_rd_data_w0, ram_wr_data_w0, ram_rd_data_w0;
  logic        m0_ack_w0, m1_ack_w0, ram_we_w0;
  logic [15:0] ram_addr_w0;
  logic [7:0]  m0_rd_data_w3, m1_rd_data_w3, ram_wr_data_w3, ram_rd_data_w3;
  logic        m0_ack_w3, m1_ack_w3, ram_we_w3;
  logic [15:0] ram_addr_w3;

  mem_arbiter #(.ADDR_W(16), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_rd_req(m0_rd_req), .m0_wr_en(m0_wr_en),
    .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data_w0), .m0_ack(m0_ack_w0),
    .m1_addr(m1_addr), .m1_rd_req(m1_rd_req), .m1_rd_data(m1_rd_data_w0),
    .m1_ack(m1_ack_w0), .ram_addr(ram_addr_w0), .ram_we(ram_we_w0),
    .ram_wr_data(ram_wr_data_w0), .ram_rd_data(ram_rd_data_w0)
  );

  mem_arbiter #(.ADDR_W(16), .WAIT_STATES(3)) dut_w3 (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_rd_req(m0_rd_req), .m0_wr_en(m0_wr_en),
    .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data_w3), .m0_ack(m0_ack_w3),
    .m1_addr(m1_addr), .m1_rd_req(m1_rd_req), .m1_rd_data(m1_rd_data_w3),
    .m1_ack(m1_ack_w3), .ram_addr(ram_addr_w3), .ram_we(ram_we_w3),
    .ram_wr_data(ram_wr_data_w3), .ram_rd_data(ram_rd_data_w3)
  );

  // RAM models with 1-cycle read latency and a bench-side load port.
  logic [7:0]  mem_w0 [0:65535];
  logic [7:0]  mem_w3 [0:65535];
  logic        ld_w0, ld_w3;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;

  always @(posedge clk) begin
    if (ld_w0)          mem_w0[ld_addr] <= ld_data;
    else if (ram_we_w0) mem_w0[ram_addr_w0] <= ram_wr_data_w0;
    ram_rd_data_w0 <= mem_w0[ram_addr_w0];
    if (ld_w3)          mem_w3[ld_addr] <= ld_data;
    else if (ram_we_w3) mem_w3[ram_addr_w3] <= ram_wr_data_w3;
    ram_rd_data_w3 <= mem_w3[ram_addr_w3];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_addr = 16'h0; m1_addr = 16'h0;
    m0_rd_req = 1'b0; m0_wr_en = 1'b0; m1_rd_req = 1'b0; m0_wr_data = 8'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d, input logic to0, input logic to3);
    @(negedge clk);
    ld_addr = a; ld_data = d; ld_w0 = to0; ld_w3 = to3;
    @(negedge clk);
    ld_w0 = 1'b0; ld_w3 = 1'b0;
  endtask

  typedef struct {
    logic        m;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_data;
    int          exp_we;
  } vec_t;

  // One isolated access on the zero-wait instance, starting from IDLE.
  task automatic apply(input vec_t v, input string tag);
    int lat;
    int wec;
    bit got;
    lat = 0; wec = 0; got = 0;
    if (v.m == MASTER_CPU) begin
      m0_addr = v.addr; m0_rd_req = v.rd; m0_wr_en = v.wr; m0_wr_data = v.wdata;
    end else begin
      m1_addr = v.addr; m1_rd_req = v.rd;
    end
    for (int k = 1; k <= 12 && !got; k++) begin
      @(negedge clk);
      if (ram_we_w0) begin
        wec++;
        chk({tag, "_we_addr"}, 32'(ram_addr_w0), 32'(v.addr));
        chk({tag, "_we_data"}, 32'(ram_wr_data_w0), 32'(v.wdata));
      end
      if (v.m == MASTER_CPU ? m0_ack_w0 : m1_ack_w0) begin
        got = 1; lat = k;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(ACK_LATENCY_BASE));
    chk({tag, "_rd_data"}, 32'(v.m == MASTER_CPU ? m0_rd_data_w0 : m1_rd_data_w0), 32'(v.exp_data));
    chk({tag, "_other_ack"}, 32'(v.m == MASTER_CPU ? m1_ack_w0 : m0_ack_w0), 32'(0));
    chk({tag, "_we_cycles"}, 32'(wec), 32'(v.exp_we));
    $display("txn %s: m%0d rd=%0d wr=%0d addr=%h lat=%0d data=%h", tag, v.m, v.rd, v.wr,
             v.addr, lat, v.m == MASTER_CPU ? m0_rd_data_w0 : m1_rd_data_w0);
    idle_inputs();
    @(negedge clk);
    chk({tag, "_ack_single"}, 32'(m0_ack_w0 | m1_ack_w0), 32'(0));
  endtask

  vec_t vecs [8];
  vec_t v;
  logic [7:0]  model [0:15];
  bit          p0, p1, w0, prev_ack;
  logic [15:0] a0, a1;
  logic [7:0]  d0, e0, e1;
  int          age0, age1, kind;
  bit          got_first;

  initial begin
    reset_n = 1'b0;
    ld_w0 = 1'b0; ld_w3 = 1'b0; ld_addr = 16'h0; ld_data = 8'h0;
    idle_inputs();

    poke(16'h0444, 8'hA9, 1'b1, 1'b0);
    poke(16'h0444, 8'h33, 1'b0, 1'b1);
    poke(16'h0445, 8'h12, 1'b1, 1'b1);
    poke(16'h2000, 8'h77, 1'b1, 1'b1);

    do_reset();
    chk("rst_m0_ack", 32'(m0_ack_w0), 32'(0));
    chk("rst_m1_ack", 32'(m1_ack_w0), 32'(0));
    chk("rst_ram_we", 32'(ram_we_w0), 32'(0));
    chk("rst_ram_addr", 32'(ram_addr_w0), 32'(0));
    chk("rst_m0_rd_data", 32'(m0_rd_data_w0), 32'(0));
    chk("rst_m1_rd_data", 32'(m1_rd_data_w3), 32'(0));

    // CPU read from cycle 0, then a word read with req held high.
    m0_addr = 16'h0444; m0_rd_req = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("seqA_ram_addr_w0", 32'(ram_addr_w0), 32'h0444);
        chk("seqA_ram_addr_w3", 32'(ram_addr_w3), 32'h0444);
      end
      chk($sformatf("seqA_m0_ack_c%0d", c), 32'(m0_ack_w0), 32'(c == 3 || c == 7));
      chk($sformatf("seqA_w3_ack_c%0d", c), 32'(m0_ack_w3), 32'(c == 6));
      chk($sformatf("seqA_w3_m1ack_c%0d", c), 32'(m1_ack_w3), 32'(0));
      if (c == 2) begin
        ld_addr = 16'h0444; ld_data = 8'hA9; ld_w3 = 1'b1;
      end
      if (c == 3) begin
        ld_w3 = 1'b0;
        chk("seqA_first_data", 32'(m0_rd_data_w0), 32'hA9);
        m0_addr = 16'h0445;
        $display("txn seqA first read addr=0444 data=%h", m0_rd_data_w0);
      end
      if (c == 6) chk("seqA_w3_data", 32'(m0_rd_data_w3), 32'hA9);
      if (c == 7) begin
        chk("seqA_word_data", 32'(m0_rd_data_w0), 32'h12);
        m0_rd_req = 1'b0;
        $display("txn seqA second read addr=0445 data=%h", m0_rd_data_w0);
      end
    end
    idle_inputs();

    vecs[0] = '{MASTER_CPU, 1'b1, 1'b0, 16'h0444, 8'h00, 8'hA9, 0};
    vecs[1] = '{MASTER_CPU, 1'b1, 1'b1, 16'h2000, 8'h5A, 8'hA9, 1};
    vecs[2] = '{MASTER_CPU, 1'b1, 1'b0, 16'h2000, 8'h00, 8'h5A, 0};
    vecs[3] = '{MASTER_VID, 1'b1, 1'b0, 16'h2000, 8'h00, 8'h5A, 0};
    vecs[4] = '{MASTER_VID, 1'b1, 1'b0, 16'h0445, 8'h00, 8'h12, 0};
    vecs[5] = '{MASTER_CPU, 1'b0, 1'b1, 16'h0445, 8'hC3, 8'h5A, 1};
    vecs[6] = '{MASTER_VID, 1'b1, 1'b0, 16'h0445, 8'h00, 8'hC3, 0};
    vecs[7] = '{MASTER_CPU, 1'b1, 1'b0, 16'h0445, 8'h00, 8'hC3, 0};
    @(negedge clk);
    for (int i = 0; i < 8; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Both masters requesting continuously from reset: M0 first, then alternate.
    do_reset();
    m0_addr = 16'h0444; m0_rd_req = 1'b1;
    m1_addr = 16'h0445; m1_rd_req = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      chk($sformatf("rr_m0_ack_c%0d", c), 32'(m0_ack_w0), 32'(c % 8 == 3));
      chk($sformatf("rr_m1_ack_c%0d", c), 32'(m1_ack_w0), 32'(c % 8 == 7));
      if (c % 8 == 3) chk("rr_m0_data", 32'(m0_rd_data_w0), 32'hA9);
      if (c % 8 == 7) chk("rr_m1_data", 32'(m1_rd_data_w0), 32'hC3);
      if (m0_ack_w0 || m1_ack_w0) $display("txn rr c=%0d m0_ack=%0d m1_ack=%0d", c, m0_ack_w0, m1_ack_w0);
    end
    idle_inputs();
    repeat (8) @(negedge clk);

    // Reset during an M1 access after both masters have completed reads.
    v = '{MASTER_VID, 1'b1, 1'b0, 16'h0444, 8'h00, 8'hA9, 0};
    apply(v, "pre_m1");
    v = '{MASTER_CPU, 1'b1, 1'b0, 16'h0445, 8'h00, 8'hC3, 0};
    apply(v, "pre_m0");
    m1_addr = 16'h2000; m1_rd_req = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    m0_addr = 16'h0444; m0_rd_req = 1'b1;
    @(negedge clk);
    chk("midrst_m0_ack", 32'(m0_ack_w0), 32'(0));
    chk("midrst_m1_ack", 32'(m1_ack_w0), 32'(0));
    chk("midrst_ram_we", 32'(ram_we_w0), 32'(0));
    chk("midrst_ram_addr", 32'(ram_addr_w0), 32'(0));
    chk("midrst_m0_data", 32'(m0_rd_data_w0), 32'(0));
    chk("midrst_m1_data", 32'(m1_rd_data_w0), 32'(0));
    reset_n = 1'b1;
    got_first = 0;
    for (int k = 1; k <= 8 && !got_first; k++) begin
      @(negedge clk);
      if (m0_ack_w0 || m1_ack_w0) begin
        got_first = 1;
        chk("midrst_first_is_m0", 32'(m0_ack_w0), 32'(1));
        chk("midrst_first_lat", 32'(k), 32'(ACK_LATENCY_BASE));
        $display("txn midrst first ack at k=%0d m0=%0d m1=%0d", k, m0_ack_w0, m1_ack_w0);
      end
    end
    chk("midrst_got_ack", 32'(got_first), 32'(1));
    idle_inputs();

    // Randomized traffic against a transaction-level memory model.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      model[i] = 8'($urandom);
      poke(16'(i), model[i], 1'b1, 1'b0);
    end
    p0 = 0; p1 = 0; w0 = 0; prev_ack = 0;
    a0 = 16'h0; a1 = 16'h0; d0 = 8'h0; e0 = 8'h0; e1 = 8'h0; age0 = 0; age1 = 0;
    for (int cyc = 0; cyc < 430; cyc++) begin
      @(negedge clk);
      chk("rnd_ack_excl", 32'(m0_ack_w0 & m1_ack_w0), 32'(0));
      chk("rnd_ack_gap", 32'(prev_ack & (m0_ack_w0 | m1_ack_w0)), 32'(0));
      prev_ack = m0_ack_w0 | m1_ack_w0;
      if (m0_ack_w0) begin
        chk("rnd_m0_ack_pending", 32'(p0), 32'(1));
        if (p0 && w0) model[a0[3:0]] = d0;
        else if (p0)  e0 = model[a0[3:0]];
        chk("rnd_m0_rd_data", 32'(m0_rd_data_w0), 32'(e0));
        $display("txn rnd m0 %s addr=%h data=%h", w0 ? "wr" : "rd", a0, w0 ? d0 : m0_rd_data_w0);
        p0 = 0;
      end else begin
        chk("rnd_m0_hold", 32'(m0_rd_data_w0), 32'(e0));
        if (p0) begin
          age0++;
          if (age0 > 10) begin
            chk("rnd_m0_wait_bound", 32'(age0), 32'(10));
            p0 = 0;
          end
        end
      end
      if (m1_ack_w0) begin
        chk("rnd_m1_ack_pending", 32'(p1), 32'(1));
        if (p1) e1 = model[a1[3:0]];
        chk("rnd_m1_rd_data", 32'(m1_rd_data_w0), 32'(e1));
        $display("txn rnd m1 rd addr=%h data=%h", a1, m1_rd_data_w0);
        p1 = 0;
      end else begin
        chk("rnd_m1_hold", 32'(m1_rd_data_w0), 32'(e1));
        if (p1) begin
          age1++;
          if (age1 > 10) begin
            chk("rnd_m1_wait_bound", 32'(age1), 32'(10));
            p1 = 0;
          end
        end
      end
      if (!p0 && cyc < 400 && $urandom_range(0, 2) == 0) begin
        a0 = 16'($urandom_range(0, 15));
        kind = int'($urandom_range(0, 2));
        w0 = (kind != 0);
        d0 = 8'($urandom);
        m0_addr = a0; m0_wr_data = d0;
        m0_wr_en = w0; m0_rd_req = (kind != 1);
        p0 = 1; age0 = 0;
      end else if (!p0) begin
        m0_rd_req = 1'b0; m0_wr_en = 1'b0; m0_addr = 16'($urandom);
      end
      if (!p1 && cyc < 400 && $urandom_range(0, 2) == 0) begin
        a1 = 16'($urandom_range(0, 15));
        m1_addr = a1; m1_rd_req = 1'b1;
        p1 = 1; age1 = 0;
      end else if (!p1) begin
        m1_rd_req = 1'b0; m1_addr = 16'($urandom);
      end
    end
    chk("rnd_m0_drained", 32'(p0), 32'(0));
    chk("rnd_m1_drained", 32'(p1), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
